// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchronizer, debounce filter, registered
// level output and one-cycle press pulse. With BUTTON_CONDITIONER_AUTO_REPEAT_EN
// defined, an IDLE/HOLD/REPEAT FSM adds auto-repeat pulses while the button
// stays pressed.
//
// Ports
//   clock_i    rising-edge clock
//   reset_n_i  asynchronous active-low reset
//   button_i   raw, bouncing, asynchronous button (active-high)
//   level_o    debounced button level (registered)
//   pulse_o    one-cycle press / auto-repeat pulse (registered)
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 256,
  parameter int unsigned REPEAT_PERIOD   = 64
) (
  input  logic clock_i,
  input  logic reset_n_i,
  input  logic button_i,
  output logic level_o,
  output logic pulse_o
);

  localparam int unsigned DBC_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q;
  logic             btn_s;
  logic [DBC_W-1:0] dbc_cnt_q, dbc_cnt_d;
  logic             level_q, level_d;
  logic             pulse_q;
  logic             rise_c;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_q <= 1'b0;
      btn_s   <= 1'b0;
    end else begin
      sync1_q <= button_i;
      btn_s   <= sync1_q;
    end
  end

  // Debounce: count cycles the synchronized input disagrees with the level,
  // flip the level once the disagreement has lasted DEBOUNCE_CYCLES cycles.
  always_comb begin
    dbc_cnt_d = '0;
    level_d   = level_q;
    if (btn_s != level_q) begin
      if (dbc_cnt_q == DBC_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
      end else if (dbc_cnt_q != '1) begin
        dbc_cnt_d = dbc_cnt_q + DBC_W'(1);
      end else begin
        dbc_cnt_d = dbc_cnt_q;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      dbc_cnt_q <= '0;
      level_q   <= 1'b0;
    end else begin
      dbc_cnt_q <= dbc_cnt_d;
      level_q   <= level_d;
    end
  end

  assign rise_c = level_d & ~level_q;

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t           state_q;
  logic [RPT_W-1:0] rpt_cnt_q;
  logic             fall_c;

  assign fall_c = ~level_d & level_q;

  // Auto-repeat FSM; a falling level always wins and suppresses the pulse.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      rpt_cnt_q <= '0;
      pulse_q   <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          rpt_cnt_q <= '0;
          if (rise_c) begin
            pulse_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (fall_c) begin
            state_q   <= IDLE;
            rpt_cnt_q <= '0;
          end else if (rpt_cnt_q == RPT_W'(REPEAT_DELAY - 1)) begin
            pulse_q   <= 1'b1;
            state_q   <= REPEAT;
            rpt_cnt_q <= '0;
          end else if (rpt_cnt_q != '1) begin
            rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
          end
        end
        REPEAT: begin
          if (fall_c) begin
            state_q   <= IDLE;
            rpt_cnt_q <= '0;
          end else if (rpt_cnt_q == RPT_W'(REPEAT_PERIOD - 1)) begin
            pulse_q   <= 1'b1;
            rpt_cnt_q <= '0;
          end else if (rpt_cnt_q != '1) begin
            rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          rpt_cnt_q <= '0;
        end
      endcase
    end
  end
`else
  // Repeat timing parameters have no function without the auto-repeat FSM.
  logic unused_cfg_c;
  assign unused_cfg_c = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};

  // Press pulse only.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= rise_c;
    end
  end
`endif

  assign level_o = level_q;
  assign pulse_o = pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: a sample-history model predicts level_o and
// pulse_o every cycle; directed scenarios add literal edge-timing checks.
module tb_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 4;

  logic clock_i   = 1'b0;
  logic reset_n_i = 1'b1;
  logic button_i  = 1'b0;
  logic level_o;
  logic pulse_o;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clock_i  (clock_i),
    .reset_n_i(reset_n_i),
    .button_i (button_i),
    .level_o  (level_o),
    .pulse_o  (pulse_o)
  );

  always #5 clock_i = ~clock_i;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;

  int pulse_edges[$];
  int rise_edges[$];
  int fall_edges[$];
  int m_pulse_edges[$];
  bit prev_level = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  always @(posedge clock_i) edge_n++;

  // Model: raw samples since reset release; the level flips when the last D
  // synchronized samples (two edges late) all disagree with it. Pulses come
  // at a rising flip and, with auto-repeat, at press+RD+m*RP while held.
  bit raw[$];
  bit m_level = 1'b0;
  bit m_pulse = 1'b0;
  int m_press = 0;

  function automatic bit raw_at(input int idx);
    if (idx < 1 || idx > raw.size()) return 1'b0;
    return raw[idx-1];
  endfunction

  always @(posedge clock_i or negedge reset_n_i) begin
    int k;
    bit flip;
    if (!reset_n_i) begin
      raw.delete();
      m_level = 1'b0;
      m_pulse = 1'b0;
      m_press = 0;
    end else begin
      raw.push_back(button_i);
      k = raw.size();
      flip = 1'b1;
      for (int j = 0; j < D; j++)
        if (raw_at(k - 2 - j) == m_level) flip = 1'b0;
      m_pulse = 1'b0;
      if (flip) begin
        m_level = ~m_level;
        if (m_level) begin
          m_pulse = 1'b1;
          m_press = k;
        end
      end
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
      else if (m_level && (k - m_press) >= RD && ((k - m_press - RD) % RP) == 0)
        m_pulse = 1'b1;
`endif
    end
  end

  // Per-cycle compare against the model, plus event logs for literal checks.
  always @(negedge clock_i) begin
    chk("level_o", int'(level_o), int'(m_level));
    chk("pulse_o", int'(pulse_o), int'(m_pulse));
    if (pulse_o) pulse_edges.push_back(edge_n);
    if (m_pulse) m_pulse_edges.push_back(edge_n);
    if (level_o && !prev_level) rise_edges.push_back(edge_n);
    if (!level_o && prev_level) fall_edges.push_back(edge_n);
    prev_level = level_o;
  end

  function automatic int nth_pulse(input int base, input int idx);
    if (base + idx < pulse_edges.size()) return pulse_edges[base + idx];
    return -1000;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clock_i);
  endtask

  initial begin
    int t0, t1, pb, pb2, rb, fb, mb;

    // Reset
    #1 reset_n_i = 1'b0;
    cycles(3);
    chk("reset level_o", int'(level_o), 0);
    chk("reset pulse_o", int'(pulse_o), 0);
    reset_n_i = 1'b1;
    cycles(5);

    // Clean press held 40 cycles, then release
    pb = pulse_edges.size(); rb = rise_edges.size(); fb = fall_edges.size();
    mb = m_pulse_edges.size();
    t0 = edge_n;
    button_i = 1'b1;
    cycles(40);
    button_i = 1'b0;
    cycles(12);
    chk("press rise edge", (rise_edges.size() > rb) ? rise_edges[rb] - t0 : -1, 6);
    chk("release fall edge", (fall_edges.size() > fb) ? fall_edges[fb] - t0 : -1, 46);
    chk("press pulse edge", nth_pulse(pb, 0) - t0, 6);
    chk("model press edge", (m_pulse_edges.size() > mb) ? m_pulse_edges[mb] - t0 : -1, 6);
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    chk("first repeat edge", nth_pulse(pb, 1) - t0, 14);
    chk("second repeat edge", nth_pulse(pb, 2) - t0, 18);
    chk("last repeat edge", nth_pulse(pb, 8) - t0, 42);
    chk("hold pulse count", pulse_edges.size() - pb, 9);
    chk("model hold pulse count", m_pulse_edges.size() - mb, 9);
`else
    chk("hold pulse count", pulse_edges.size() - pb, 1);
    chk("model hold pulse count", m_pulse_edges.size() - mb, 1);
`endif

    // Bounce 1,0,1,0 then stable 1
    pb = pulse_edges.size(); rb = rise_edges.size(); fb = fall_edges.size();
    t0 = edge_n;
    button_i = 1'b1; cycles(1);
    button_i = 1'b0; cycles(1);
    button_i = 1'b1; cycles(1);
    button_i = 1'b0; cycles(1);
    button_i = 1'b1; cycles(12);
    button_i = 1'b0; cycles(12);
    chk("bounce rise edge", (rise_edges.size() > rb) ? rise_edges[rb] - t0 : -1, 10);
    chk("bounce rise count", rise_edges.size() - rb, 1);
    chk("bounce press pulse", nth_pulse(pb, 0) - t0, 10);
    chk("bounce fall edge", (fall_edges.size() > fb) ? fall_edges[fb] - t0 : -1, 22);
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    chk("bounce pulse count", pulse_edges.size() - pb, 2);
`else
    chk("bounce pulse count", pulse_edges.size() - pb, 1);
`endif

    // Glitch of D-1 synchronized cycles must be ignored
    pb = pulse_edges.size(); rb = rise_edges.size();
    button_i = 1'b1; cycles(D - 1);
    button_i = 1'b0; cycles(10);
    chk("glitch rise count", rise_edges.size() - rb, 0);
    chk("glitch pulse count", pulse_edges.size() - pb, 0);

    // Reset asserted mid-repeat with the button held
    pb = pulse_edges.size();
    t0 = edge_n;
    button_i = 1'b1;
    cycles(20);
    chk("level before reset", int'(level_o), 1);
    #2 reset_n_i = 1'b0;
    #1;
    chk("async reset level_o", int'(level_o), 0);
    chk("async reset pulse_o", int'(pulse_o), 0);
    cycles(3);
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    chk("pulses before reset", pulse_edges.size() - pb, 3);
`else
    chk("pulses before reset", pulse_edges.size() - pb, 1);
`endif
    reset_n_i = 1'b1;
    t1 = edge_n;
    pb2 = pulse_edges.size();
    cycles(20);
    button_i = 1'b0;
    cycles(12);
    chk("post-reset press edge", nth_pulse(pb2, 0) - t1, 6);
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    chk("post-reset first repeat", nth_pulse(pb2, 1) - t1, 14);
    chk("post-reset pulse count", pulse_edges.size() - pb2, 4);
`else
    chk("post-reset pulse count", pulse_edges.size() - pb2, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
